// File: rtl/cmm_rr_pkt_arb.sv
// cmm_rr_pkt_arb: N-way round-robin packet arbiter onto one valid/ready stream.
// The grant is held for a whole packet and rotates after the last beat. The datapath
// is a zero-latency bypass: the winner's valid/data/last appear at the output in the
// same cycle.
// Optional feature macro: CMM_RR_ARB_STAT_EN adds the o_pkt_cnt per-source
// completed-packet counters (16-bit, saturating).
//
// state  | meaning
// S_IDLE | no packet in flight; pick the first valid requester starting at r_rr_ptr
// S_LOCK | packet in flight; grant pinned to r_lock_id until its last beat transfers
module cmm_rr_pkt_arb #(
  parameter int NREQ   = 4,
  parameter int DWIDTH = 16
) (
  input  logic                         i_clk,
  input  logic                         rst,
  input  logic [NREQ-1:0]              i_req_valid,
  input  logic [NREQ-1:0]              i_req_last,
  input  logic [NREQ*DWIDTH-1:0]       i_req_data,
  output logic [NREQ-1:0]              o_req_ready,
  output logic                         o_valid,
  output logic                         o_last,
  output logic [DWIDTH-1:0]            o_data,
  output logic [$clog2(NREQ)-1:0]      o_src_id,
  input  logic                         i_ready
`ifdef CMM_RR_ARB_STAT_EN
  ,output logic [NREQ*16-1:0]          o_pkt_cnt
`endif
);

  localparam int IDW = $clog2(NREQ);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_LOCK = 1'b1;

  logic [0:0]     r_state;
  logic [IDW-1:0] r_lock_id;
  logic [IDW-1:0] r_rr_ptr;

  logic           w_found;
  logic [IDW-1:0] w_search_id;
  logic           w_gnt_act;
  logic [IDW-1:0] w_gnt_id;
  logic           w_xfer_last;

  // Modulo-NREQ add; the wrap is explicit so non-power-of-2 NREQ never yields NREQ.
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return s[IDW-1:0];
  endfunction

  // Round-robin search for the first valid requester starting at r_rr_ptr.
  always_comb begin
    w_found     = 1'b0;
    w_search_id = r_rr_ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && i_req_valid[wrap_add(r_rr_ptr, k)]) begin
        w_found     = 1'b1;
        w_search_id = wrap_add(r_rr_ptr, k);
      end
    end
  end

  // Grant selection: pinned while locked, otherwise the search result.
  always_comb begin
    w_gnt_act = (r_state == S_LOCK) || w_found;
    w_gnt_id  = (r_state == S_LOCK) ? r_lock_id : w_search_id;
  end

  // Bypass datapath; o_src_id shows r_rr_ptr when nothing is granted.
  always_comb begin
    o_req_ready = '0;
    o_valid     = 1'b0;
    o_last      = 1'b0;
    o_data      = '0;
    o_src_id    = w_gnt_id;
    if (w_gnt_act) begin
      o_valid               = i_req_valid[w_gnt_id];
      o_last                = i_req_last[w_gnt_id];
      o_data                = i_req_data[w_gnt_id*DWIDTH +: DWIDTH];
      o_req_ready[w_gnt_id] = i_ready;
    end
    w_xfer_last = o_valid && i_ready && o_last;
  end

  // Arbitration FSM. A granted but stalled beat also locks, so the grant cannot
  // move while o_valid is held without ready.
  always_ff @(posedge i_clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_lock_id <= '0;
      r_rr_ptr  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            if (w_xfer_last) begin
              r_rr_ptr <= wrap_add(w_search_id, 1);
            end else begin
              r_state   <= S_LOCK;
              r_lock_id <= w_search_id;
            end
          end
        end
        S_LOCK: begin
          if (w_xfer_last) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= wrap_add(r_lock_id, 1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef CMM_RR_ARB_STAT_EN
  logic [15:0] r_pkt_cnt [NREQ];

  // Per-source completed-packet counters, saturating at all ones.
  always_ff @(posedge i_clk) begin
    if (rst) begin
      for (int k = 0; k < NREQ; k++) r_pkt_cnt[k] <= '0;
    end else if (w_xfer_last && (r_pkt_cnt[w_gnt_id] != 16'hFFFF)) begin
      r_pkt_cnt[w_gnt_id] <= r_pkt_cnt[w_gnt_id] + 16'd1;
    end
  end

  for (genvar gk = 0; gk < NREQ; gk++) begin : g_cnt_out
    assign o_pkt_cnt[gk*16 +: 16] = r_pkt_cnt[gk];
  end
`endif

endmodule

// File: tb/tb_cmm_rr_pkt_arb.sv
// tb_cmm_rr_pkt_arb: scoreboard bench for cmm_rr_pkt_arb (NREQ=4, DWIDTH=16).
// The counter checks are only built when CMM_RR_ARB_STAT_EN is defined.
module tb_cmm_rr_pkt_arb;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_last;
  logic [63:0] req_data;
  logic [3:0]  o_req_ready;
  logic        o_valid;
  logic        o_last;
  logic [15:0] o_data;
  logic [1:0]  o_src_id;
  logic        ready;
`ifdef CMM_RR_ARB_STAT_EN
  logic [63:0] o_pkt_cnt;
`endif

  cmm_rr_pkt_arb #(.NREQ(4), .DWIDTH(16)) dut (
    .i_clk       (clk),
    .rst         (rst),
    .i_req_valid (req_valid),
    .i_req_last  (req_last),
    .i_req_data  (req_data),
    .o_req_ready (o_req_ready),
    .o_valid     (o_valid),
    .o_last      (o_last),
    .o_data      (o_data),
    .o_src_id    (o_src_id),
    .i_ready     (ready)
`ifdef CMM_RR_ARB_STAT_EN
    ,.o_pkt_cnt  (o_pkt_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] d;
    logic        l;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] id, input logic [15:0] d, input logic l);
    exp_t e;
    e.id = id; e.d = d; e.l = l;
    sb.push_back(e);
  endtask

  task automatic set_req(input int k, input logic v, input logic l, input logic [15:0] d);
    req_valid[k]         = v;
    req_last[k]          = l;
    req_data[k*16 +: 16] = d;
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  // Every downstream transfer is matched against the next expected beat.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && o_valid && ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_xfer", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("sb_id",   32'(o_src_id), 32'(e.id));
        chk("sb_data", 32'(o_data),   32'(e.d));
        chk("sb_last", 32'(o_last),   32'(e.l));
      end
    end
  end

  initial begin
    rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_src",   32'(o_src_id), 0);
    chk("rst_rdy",   32'(o_req_ready), 0);
    chk("rst_data",  32'(o_data), 0);
    nxt;

    // T1: all four requesters, single-beat packets, strict rotation
    for (int k = 0; k < 4; k++) set_req(k, 1'b1, 1'b1, 16'(k * 16'h1111));
    for (int i = 0; i < 5; i++) push(2'(i % 4), 16'((i % 4) * 16'h1111), 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t1_src", 32'(o_src_id), 32'(i % 4));
      nxt;
    end
    for (int k = 0; k < 4; k++) set_req(k, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    chk("t1_idle_valid", 32'(o_valid), 0);
    chk("t1_idle_src",   32'(o_src_id), 1);
    nxt;

    // T2: req1 three-beat packet, req2 waits
    set_req(1, 1'b1, 1'b0, 16'h2100);
    set_req(2, 1'b1, 1'b1, 16'h2200);
    push(1, 16'h2100, 0); push(1, 16'h2101, 0); push(1, 16'h2102, 1); push(2, 16'h2200, 1);
    @(negedge clk);
    chk("t2_b0_src", 32'(o_src_id), 1);
    chk("t2_b0_rdy", 32'(o_req_ready), 32'b0010);
    nxt;
    set_req(1, 1'b1, 1'b0, 16'h2101);
    @(negedge clk);
    chk("t2_b1_src", 32'(o_src_id), 1);
    chk("t2_b1_rdy", 32'(o_req_ready), 32'b0010);
    nxt;
    set_req(1, 1'b1, 1'b1, 16'h2102);
    @(negedge clk);
    chk("t2_b2_src", 32'(o_src_id), 1);
    nxt;
    set_req(1, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    chk("t2_r2_src", 32'(o_src_id), 2);
    chk("t2_r2_rdy", 32'(o_req_ready), 32'b0100);
    nxt;
    set_req(2, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    chk("t2_idle_valid", 32'(o_valid), 0);
    chk("t2_idle_src",   32'(o_src_id), 3);
    nxt;

    // T3: stalled beat keeps its grant while another requester arrives
    ready = 1'b0;
    set_req(0, 1'b1, 1'b1, 16'hA5A5);
    push(0, 16'hA5A5, 1); push(3, 16'h3333, 1);
    for (int c = 0; c < 4; c++) begin
      if (c == 1) set_req(3, 1'b1, 1'b1, 16'h3333);
      @(negedge clk);
      chk("t3_stall_src",   32'(o_src_id), 0);
      chk("t3_stall_data",  32'(o_data), 32'hA5A5);
      chk("t3_stall_valid", 32'(o_valid), 1);
      chk("t3_stall_rdy",   32'(o_req_ready), 0);
      nxt;
    end
    ready = 1'b1;
    @(negedge clk);
    chk("t3_go_src", 32'(o_src_id), 0);
    chk("t3_go_rdy", 32'(o_req_ready), 32'b0001);
    nxt;
    set_req(0, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    chk("t3_rot_src", 32'(o_src_id), 3);
    nxt;
    set_req(3, 1'b0, 1'b0, 16'h0);

    // T4: locked source drops valid mid-packet; other requester is held off
    set_req(2, 1'b1, 1'b0, 16'h4200);
    push(2, 16'h4200, 0);
    @(negedge clk);
    chk("t4_b0_src", 32'(o_src_id), 2);
    nxt;
    set_req(2, 1'b0, 1'b0, 16'h0);
    set_req(0, 1'b1, 1'b1, 16'h4000);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t4_gap_valid", 32'(o_valid), 0);
      chk("t4_gap_rdy",   32'(o_req_ready), 32'b0100);
      chk("t4_gap_src",   32'(o_src_id), 2);
      nxt;
    end
    set_req(2, 1'b1, 1'b1, 16'h4201);
    push(2, 16'h4201, 1); push(0, 16'h4000, 1);
    @(negedge clk);
    chk("t4_b1_src",   32'(o_src_id), 2);
    chk("t4_b1_valid", 32'(o_valid), 1);
    nxt;
    set_req(2, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    chk("t4_r0_src",  32'(o_src_id), 0);
    chk("t4_r0_data", 32'(o_data), 32'h4000);
    nxt;
    set_req(0, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    chk("t4_idle_src", 32'(o_src_id), 1);
    nxt;

    // T5: reset in the middle of req3's packet
    set_req(3, 1'b1, 1'b0, 16'h5300);
    push(3, 16'h5300, 0);
    @(negedge clk);
    chk("t5_b0_src", 32'(o_src_id), 3);
    nxt;
    set_req(3, 1'b1, 1'b0, 16'h5301);
    push(3, 16'h5301, 0);
    @(negedge clk);
    nxt;
    rst = 1'b1; ready = 1'b0;
    set_req(3, 1'b1, 1'b0, 16'h5302);
    @(negedge clk);
    nxt;
    rst = 1'b0; ready = 1'b1;
    set_req(0, 1'b1, 1'b1, 16'h5000);
    set_req(3, 1'b1, 1'b1, 16'h5310);
    push(0, 16'h5000, 1); push(3, 16'h5310, 1);
    @(negedge clk);
    chk("t5_after_rst_src", 32'(o_src_id), 0);
    nxt;
    set_req(0, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    chk("t5_next_src", 32'(o_src_id), 3);
    nxt;
    set_req(3, 1'b0, 1'b0, 16'h0);

`ifdef CMM_RR_ARB_STAT_EN
    // T6: packet counters, including saturation
    @(negedge clk);
    chk("t6_cnt0_post_rst", 32'(o_pkt_cnt[15:0]), 1);
    chk("t6_cnt3_post_rst", 32'(o_pkt_cnt[63:48]), 1);
    nxt;
    set_req(1, 1'b1, 1'b1, 16'h6100);
    for (int i = 0; i < 5; i++) begin
      push(1, 16'h6100, 1);
      nxt;
    end
    set_req(1, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    chk("t6_cnt1", 32'(o_pkt_cnt[31:16]), 5);
    nxt;
    set_req(2, 1'b1, 1'b1, 16'h6200);
    for (int i = 0; i < 65540; i++) begin
      push(2, 16'h6200, 1);
      nxt;
    end
    set_req(2, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    chk("t6_cnt2_sat", 32'(o_pkt_cnt[47:32]), 32'hFFFF);
    chk("t6_cnt1_kept", 32'(o_pkt_cnt[31:16]), 5);
    nxt;
`endif

    @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
